// File: rtl/dma_target_port_pkg.sv
// Shared types and constants for the DMA target port.
// Region codes, FSM states, register indices and CTRL fields.
package dma_target_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic [1:0] SEL_MMIO = 2'b00;
  localparam logic [1:0] SEL_DMEM = 2'b01;
  localparam logic [1:0] SEL_PMEM = 2'b10;

  localparam logic [15:0] MMIO_END = 16'h01FF;

  localparam int REG_CTRL = 0;
  localparam int REG_STAT = 1;
  localparam int REG_CNT  = 2;
  localparam int REG_LAST = 3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_WP       = 1;
  localparam int CTRL_WAIT_LSB = 4;
  localparam int STAT_ERR      = 1;

  function automatic logic in_range(
    input logic [15:0] a,
    input logic [15:0] lo,
    input logic [15:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/dma_region_decode.sv
// Maps a DMA word address onto MMIO/DMEM/PMEM and flags
// unmapped accesses or writes into write-protected PMEM.
module dma_region_decode
  import dma_target_port_pkg::*;
#(
  parameter logic [15:0] DMEM_BASE = 16'h0200,
  parameter logic [15:0] DMEM_SIZE = 16'h0800,
  parameter logic [15:0] PMEM_BASE = 16'hE000
) (
  input  logic [14:0] addr,
  input  logic [1:0]  we,
  input  logic        pmem_wp,
  output logic [1:0]  sel,
  output logic        err
);

  localparam logic [15:0] DMEM_END =
    DMEM_BASE + DMEM_SIZE - 16'd1;

  logic [15:0] ba;
  logic        is_mmio;
  logic        is_dmem;
  logic        is_pmem;

  assign ba      = {addr, 1'b0};
  assign is_mmio = ba <= MMIO_END;
  assign is_dmem = in_range(ba, DMEM_BASE, DMEM_END);
  assign is_pmem = ba >= PMEM_BASE;

  always_comb begin
    sel = SEL_MMIO;
    err = 1'b0;
    unique case (1'b1)
      is_mmio: sel = SEL_MMIO;
      is_dmem: sel = SEL_DMEM;
      is_pmem: begin
        sel = SEL_PMEM;
        err = pmem_wp & (|we);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dma_target_port.sv
// DMA responder: captures one request, waits, strobes the
// backend once and pulses dma_ready; CSRs on the peripheral bus.
module dma_target_port
  import dma_target_port_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0098,
  parameter int unsigned DEC_WD    = 2,
  parameter logic [15:0] DMEM_BASE = 16'h0200,
  parameter logic [15:0] DMEM_SIZE = 16'h0800,
  parameter logic [15:0] PMEM_BASE = 16'hE000
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic [14:0] dma_addr,
  input  logic [15:0] dma_din,
  input  logic        dma_en,
  input  logic [1:0]  dma_we,
  output logic [15:0] dma_dout,
  output logic        dma_ready,
  output logic        dma_resp,
  output logic        mem_cen,
  output logic [1:0]  mem_sel,
  output logic [14:0] mem_addr,
  output logic [1:0]  mem_we,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic [15:0] trace
);

  state_e      state;
  logic        ctrl_en;
  logic        ctrl_wp;
  logic [3:0]  ctrl_wait;
  logic        stat_err;
  logic [15:0] cnt;
  logic [15:0] last;

  logic [3:0]  wcnt;
  logic [14:0] l_addr;
  logic [1:0]  l_we;
  logic [15:0] l_din;
  logic [1:0]  l_sel;
  logic        l_err;

  logic [1:0]  dec_sel;
  logic        dec_err;

  logic              reg_sel;
  logic [DEC_WD-1:0] reg_idx;
  logic              wr_lo;
  logic              wr_hi;
  logic              rd;
  logic              sel_ctrl;
  logic              sel_stat;
  logic              sel_cnt;
  logic              sel_last;
  logic              accept;
  logic              done;

  assign reg_sel = per_en &
    (per_addr[13:DEC_WD] == BASE_ADDR[14:DEC_WD+1]);
  assign reg_idx  = per_addr[DEC_WD-1:0];
  assign wr_lo    = reg_sel & per_we[0];
  assign wr_hi    = reg_sel & per_we[1];
  assign rd       = reg_sel & ~(|per_we);
  assign sel_ctrl = reg_idx == DEC_WD'(REG_CTRL);
  assign sel_stat = reg_idx == DEC_WD'(REG_STAT);
  assign sel_cnt  = reg_idx == DEC_WD'(REG_CNT);
  assign sel_last = reg_idx == DEC_WD'(REG_LAST);

  assign accept = (state == ST_IDLE) & dma_en & ctrl_en;
  assign done   = state == ST_RESP;

  dma_region_decode #(
    .DMEM_BASE (DMEM_BASE),
    .DMEM_SIZE (DMEM_SIZE),
    .PMEM_BASE (PMEM_BASE)
  ) u_dec (
    .addr    (dma_addr),
    .we      (dma_we),
    .pmem_wp (ctrl_wp),
    .sel     (dec_sel),
    .err     (dec_err)
  );

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      ctrl_en   <= 1'b0;
      ctrl_wp   <= 1'b0;
      ctrl_wait <= '0;
      stat_err  <= 1'b0;
      cnt       <= '0;
      last      <= '0;
    end else begin
      if (sel_ctrl & wr_lo) begin
        ctrl_en   <= per_din[CTRL_EN];
        ctrl_wp   <= per_din[CTRL_WP];
        ctrl_wait <= per_din[CTRL_WAIT_LSB +: 4];
      end
      // A new error outranks a clear in the same cycle
      if (done & l_err)
        stat_err <= 1'b1;
      else if (sel_stat & wr_lo & per_din[STAT_ERR])
        stat_err <= 1'b0;
      if (sel_cnt & (wr_lo | wr_hi)) begin
        if (wr_lo) cnt[7:0]  <= per_din[7:0];
        if (wr_hi) cnt[15:8] <= per_din[15:8];
      end else if (done & ~(&cnt)) begin
        cnt <= cnt + 16'd1;
      end
      if (accept)
        last <= {dma_addr, 1'b0};
    end
  end

  always_comb begin
    per_dout = '0;
    if (rd) begin
      unique case (1'b1)
        sel_ctrl: per_dout =
          {8'h00, ctrl_wait, 2'b00, ctrl_wp, ctrl_en};
        sel_stat: per_dout =
          {14'h0, stat_err, state != ST_IDLE};
        sel_cnt:  per_dout = cnt;
        sel_last: per_dout = last;
        default:  per_dout = '0;
      endcase
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      l_addr    <= '0;
      l_we      <= '0;
      l_din     <= '0;
      l_sel     <= '0;
      l_err     <= 1'b0;
      mem_cen   <= 1'b0;
      dma_ready <= 1'b0;
      dma_resp  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            l_addr <= dma_addr;
            l_we   <= dma_we;
            l_din  <= dma_din;
            l_sel  <= dec_sel;
            l_err  <= dec_err;
            wcnt   <= ctrl_wait;
            if (dec_err) begin
              state     <= ST_RESP;
              dma_ready <= 1'b1;
              dma_resp  <= 1'b1;
            end else if (ctrl_wait != 4'd0) begin
              state <= ST_WAIT;
            end else begin
              state   <= ST_ACCESS;
              mem_cen <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1) begin
            state   <= ST_ACCESS;
            mem_cen <= 1'b1;
          end
        end
        ST_ACCESS: begin
          mem_cen   <= 1'b0;
          state     <= ST_RESP;
          dma_ready <= 1'b1;
          dma_resp  <= l_err;
        end
        ST_RESP: begin
          dma_ready <= 1'b0;
          dma_resp  <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) trace <= '0;
    else         trace <= {trace[14:0], dma_ready};
  end

  assign mem_sel  = mem_cen ? l_sel  : '0;
  assign mem_addr = mem_cen ? l_addr : '0;
  assign mem_we   = mem_cen ? l_we   : '0;
  assign mem_din  = mem_cen ? l_din  : '0;

  assign dma_dout =
    (dma_ready & ~dma_resp & ~(|l_we)) ? mem_dout : '0;

endmodule

// File: tb/tb_dma_target_port.sv
// Directed bench for dma_target_port: latency, regions,
// write protect, CSRs, saturation and mid-transfer reset.
module tb_dma_target_port;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic [15:0] dma_dout;
  logic        dma_ready;
  logic        dma_resp;
  logic        mem_cen;
  logic [1:0]  mem_sel;
  logic [14:0] mem_addr;
  logic [1:0]  mem_we;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic [15:0] trace;

  localparam logic [13:0] A_CTRL = 14'h004C;
  localparam logic [13:0] A_STAT = 14'h004D;
  localparam logic [13:0] A_CNT  = 14'h004E;
  localparam logic [13:0] A_LAST = 14'h004F;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  cap_sel;
  logic [14:0] cap_addr;
  logic [1:0]  cap_we;
  logic [15:0] cap_din;

  always #5 mclk = ~mclk;

  dma_target_port dut (
    .mclk      (mclk),
    .puc_rst   (puc_rst),
    .per_addr  (per_addr),
    .per_din   (per_din),
    .per_en    (per_en),
    .per_we    (per_we),
    .per_dout  (per_dout),
    .dma_addr  (dma_addr),
    .dma_din   (dma_din),
    .dma_en    (dma_en),
    .dma_we    (dma_we),
    .dma_dout  (dma_dout),
    .dma_ready (dma_ready),
    .dma_resp  (dma_resp),
    .mem_cen   (mem_cen),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .trace     (trace)
  );

  task automatic per_write(
    input logic [13:0] a,
    input logic [15:0] d,
    input logic [1:0]  we
  );
    per_addr = a;
    per_din  = d;
    per_we   = we;
    per_en   = 1'b1;
    @(posedge mclk); #1;
    per_en = 1'b0;
    per_we = 2'b00;
  endtask

  task automatic per_read(
    input  logic [13:0] a,
    output logic [15:0] d
  );
    per_addr = a;
    per_we   = 2'b00;
    per_en   = 1'b1;
    #1;
    d      = per_dout;
    per_en = 1'b0;
  endtask

  task automatic dma_xfer(
    input  logic [15:0] ba,
    input  logic [1:0]  we,
    input  logic [15:0] din,
    output int          rdy_n,
    output int          cen_n,
    output logic        resp,
    output logic [15:0] dout
  );
    rdy_n    = -1;
    cen_n    = -1;
    resp     = 1'b0;
    dout     = '0;
    cap_sel  = 2'bxx;
    dma_addr = ba[15:1];
    dma_we   = we;
    dma_din  = din;
    dma_en   = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge mclk); #1;
      dma_en = 1'b0;
      if (mem_cen) begin
        cen_n    = n;
        cap_sel  = mem_sel;
        cap_addr = mem_addr;
        cap_we   = mem_we;
        cap_din  = mem_din;
      end
      if (dma_ready) begin
        rdy_n = n;
        resp  = dma_resp;
        dout  = dma_dout;
        break;
      end
    end
    @(posedge mclk); #1;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    n_checks++;
    if ({dma_ready, dma_resp, mem_cen} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_out: got %b want 000",
        {dma_ready, dma_resp, mem_cen});
    end
    n_checks++;
    if (trace !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_trace: got %h want 0000", trace);
    end
    n_checks++;
    if (per_dout !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_pdout: got %h want 0000", per_dout);
    end
    per_read(A_CTRL, v);
    n_checks++;
    if (v !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h want 0000", v);
    end
    per_read(A_CNT, v);
    n_checks++;
    if (v !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h want 0000", v);
    end
  endtask

  task automatic test_read();
    int rn, cn;
    logic rs;
    logic [15:0] d;
    per_write(A_CTRL, 16'h0001, 2'b11);
    mem_dout = 16'hA5A5;
    dma_xfer(16'h0200, 2'b00, 16'h0, rn, cn, rs, d);
    n_checks++;
    if (rn !== 2 || cn !== 1) begin
      n_fail++;
      $display("FAIL rd_lat: got rdy=%0d cen=%0d want 2 1",
        rn, cn);
    end
    n_checks++;
    if (d !== 16'hA5A5 || rs !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_data: got %h/%b want a5a5/0", d, rs);
    end
    n_checks++;
    if (cap_sel !== 2'b01 || cap_addr !== 15'h0100) begin
      n_fail++;
      $display("FAIL rd_mem: got sel=%b addr=%h want 01 0100",
        cap_sel, cap_addr);
    end
    n_checks++;
    if (trace !== 16'h0001) begin
      n_fail++;
      $display("FAIL trace: got %h want 0001", trace);
    end
  endtask

  task automatic test_wait_write();
    int rn, cn;
    logic rs;
    logic [15:0] d, v;
    per_write(A_CTRL, 16'h0031, 2'b01);
    dma_xfer(16'h0210, 2'b11, 16'h1234, rn, cn, rs, d);
    n_checks++;
    if (rn !== 5 || cn !== 4) begin
      n_fail++;
      $display("FAIL wr_lat: got rdy=%0d cen=%0d want 5 4",
        rn, cn);
    end
    n_checks++;
    if (cap_we !== 2'b11 || cap_din !== 16'h1234 ||
        cap_addr !== 15'h0108) begin
      n_fail++;
      $display("FAIL wr_mem: got we=%b din=%h a=%h want 11 1234 0108",
        cap_we, cap_din, cap_addr);
    end
    n_checks++;
    if (rs !== 1'b0 || d !== 16'h0) begin
      n_fail++;
      $display("FAIL wr_resp: got %b/%h want 0/0000", rs, d);
    end
    per_read(A_CNT, v);
    n_checks++;
    if (v !== 16'h0002) begin
      n_fail++;
      $display("FAIL wr_cnt: got %h want 0002", v);
    end
  endtask

  task automatic test_pmem_wp();
    int rn, cn;
    logic rs;
    logic [15:0] d, v;
    per_write(A_CTRL, 16'h0003, 2'b01);
    dma_xfer(16'hE000, 2'b01, 16'hBEEF, rn, cn, rs, d);
    n_checks++;
    if (rn !== 1 || cn !== -1 || rs !== 1'b1) begin
      n_fail++;
      $display("FAIL wp_err: got rdy=%0d cen=%0d resp=%b want 1 -1 1",
        rn, cn, rs);
    end
    per_read(A_STAT, v);
    n_checks++;
    if (v !== 16'h0002) begin
      n_fail++;
      $display("FAIL wp_stat: got %h want 0002", v);
    end
    per_read(A_LAST, v);
    n_checks++;
    if (v !== 16'hE000) begin
      n_fail++;
      $display("FAIL wp_last: got %h want e000", v);
    end
    per_write(A_STAT, 16'h0002, 2'b01);
    per_read(A_STAT, v);
    n_checks++;
    if (v !== 16'h0000) begin
      n_fail++;
      $display("FAIL err_clr: got %h want 0000", v);
    end
    dma_xfer(16'hE002, 2'b00, 16'h0, rn, cn, rs, d);
    n_checks++;
    if (rn !== 2 || rs !== 1'b0 || cap_sel !== 2'b10 ||
        d !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL wp_rd: got rdy=%0d resp=%b sel=%b d=%h want 2 0 10 a5a5",
        rn, rs, cap_sel, d);
    end
  endtask

  task automatic test_regions();
    int rn, cn;
    logic rs;
    logic [15:0] d;
    per_write(A_CTRL, 16'h0001, 2'b01);
    dma_xfer(16'h0A00, 2'b00, 16'h0, rn, cn, rs, d);
    n_checks++;
    if (rn !== 1 || rs !== 1'b1 || d !== 16'h0 ||
        cn !== -1) begin
      n_fail++;
      $display("FAIL unmapped: got rdy=%0d resp=%b d=%h cen=%0d",
        rn, rs, d, cn);
    end
    dma_xfer(16'h09FE, 2'b00, 16'h0, rn, cn, rs, d);
    n_checks++;
    if (rs !== 1'b0 || cap_sel !== 2'b01) begin
      n_fail++;
      $display("FAIL dmem_end: got resp=%b sel=%b want 0 01",
        rs, cap_sel);
    end
    dma_xfer(16'h01FE, 2'b00, 16'h0, rn, cn, rs, d);
    n_checks++;
    if (rs !== 1'b0 || cap_sel !== 2'b00 || rn !== 2) begin
      n_fail++;
      $display("FAIL mmio_end: got resp=%b sel=%b rdy=%0d want 0 00 2",
        rs, cap_sel, rn);
    end
  endtask

  task automatic test_disabled();
    int nr, nc;
    nr = 0;
    nc = 0;
    per_write(A_CTRL, 16'h0000, 2'b01);
    dma_addr = 15'h0100;
    dma_we   = 2'b00;
    dma_en   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge mclk); #1;
      if (dma_ready) nr++;
      if (mem_cen) nc++;
    end
    dma_en = 1'b0;
    n_checks++;
    if (nr !== 0 || nc !== 0) begin
      n_fail++;
      $display("FAIL disabled: got ready=%0d cen=%0d want 0 0",
        nr, nc);
    end
  endtask

  task automatic test_cnt_sat();
    int rn, cn;
    logic rs;
    logic [15:0] d, v;
    per_write(A_CTRL, 16'h0001, 2'b01);
    per_write(A_CNT, 16'hFFFE, 2'b11);
    for (int i = 0; i < 3; i++)
      dma_xfer(16'h0200, 2'b00, 16'h0, rn, cn, rs, d);
    per_read(A_CNT, v);
    n_checks++;
    if (v !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL cnt_sat: got %h want ffff", v);
    end
    per_write(A_CNT, 16'h0000, 2'b11);
    dma_xfer(16'h0200, 2'b00, 16'h0, rn, cn, rs, d);
    per_read(A_CNT, v);
    n_checks++;
    if (v !== 16'h0001) begin
      n_fail++;
      $display("FAIL cnt_load: got %h want 0001", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    pat      = '0;
    dma_addr = 15'h0180;
    dma_we   = 2'b00;
    dma_en   = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge mclk); #1;
      pat[n-1] = dma_ready;
    end
    dma_en = 1'b0;
    @(posedge mclk); #1;
    n_checks++;
    if (pat !== 6'b010010) begin
      n_fail++;
      $display("FAIL b2b: got %b want 010010", pat);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    per_write(A_CTRL, 16'h00F1, 2'b01);
    dma_addr = 15'h0100;
    dma_we   = 2'b00;
    dma_en   = 1'b1;
    @(posedge mclk); #1;
    dma_en = 1'b0;
    @(posedge mclk); #1;
    @(posedge mclk); #1;
    per_read(A_STAT, v);
    n_checks++;
    if (v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy: got %b want 1", v[0]);
    end
    puc_rst = 1'b1;
    #1;
    n_checks++;
    if ({dma_ready, dma_resp, mem_cen} !== 3'b000 ||
        trace !== 16'h0 || mem_addr !== 15'h0 ||
        dma_dout !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got rdy=%b cen=%b trace=%h",
        dma_ready, mem_cen, trace);
    end
    @(posedge mclk); #1;
    puc_rst = 1'b0;
    per_read(A_STAT, v);
    n_checks++;
    if (v !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_stat: got %h want 0000", v);
    end
    per_read(A_LAST, v);
    n_checks++;
    if (v !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_last: got %h want 0000", v);
    end
    per_read(A_CTRL, v);
    n_checks++;
    if (v !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_ctrl: got %h want 0000", v);
    end
  endtask

  initial begin
    puc_rst  = 1'b1;
    per_addr = '0;
    per_din  = '0;
    per_en   = 1'b0;
    per_we   = '0;
    dma_addr = '0;
    dma_din  = '0;
    dma_en   = 1'b0;
    dma_we   = '0;
    mem_dout = '0;
    repeat (3) @(posedge mclk);
    #1;
    puc_rst = 1'b0;
    @(posedge mclk); #1;
    test_reset();
    test_read();
    test_wait_write();
    test_pmem_wp();
    test_regions();
    test_disabled();
    test_cnt_sat();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
